// File: rtl/inst_fetch_pkg.sv
// Shared core types for the fetch path.
// Bus word, instruction view and fetch buffer entry.
package inst_fetch_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef logic [31:0] dataBus_t;

  typedef union packed {
    logic [31:0] raw;
    struct packed {
      logic [24:0] body;
      logic [6:0]  opcode;
    } f;
  } instruction_u;

  typedef struct packed {
    dataBus_t     pc;
    instruction_u inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch bus: instruction memory request side and
// decode-facing valid/ready side.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic         rd_en;
  dataBus_t     addr;
  instruction_u instruction;
  logic         inst_ready;

  logic         if_valid;
  logic         if_ready;
  instruction_u if_inst;
  dataBus_t     if_pc;

  modport master (
    output rd_en, addr, if_valid, if_inst, if_pc,
    input  instruction, inst_ready, if_ready
  );

  modport slave (
    input  rd_en, addr, if_valid, if_inst, if_pc,
    output instruction, inst_ready, if_ready
  );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count.
// Storage clears on reset so the head reads zero when idle.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (rst) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
        for (int i = 0; i < DEPTH; i++)
          mem_q[i] <= '0;
      end else begin
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        cnt_q <= cnt_d;
        if (push_i && !flush_i)
          mem_q[wr_q] <= din_i;
      end
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, memory requests, redirects,
// and a small buffer toward decode.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_VECTOR,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  inst_fetch_if.master       bus,
  input  logic               redirect_en,
  input  dataBus_t           redirect_pc,
  output logic               fetch_misaligned
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dataBus_t      pc_q, pc_d;
  logic          mis_q, mis_d;
  logic [CW-1:0] count;
  fetch_entry_t  entry;
  fetch_entry_t  head;
  logic          capture;
  logic          pop;

  // Request is independent of this cycle's pop: no if_ready -> rd_en path.
  assign bus.rd_en = clk_en & ~rst & (count < CW'(FIFO_DEPTH));
  assign bus.addr  = {2'b00, pc_q[31:2]};

  assign capture = bus.rd_en & bus.inst_ready;
  assign bus.if_valid = (count != '0) & ~redirect_en;
  assign pop = bus.if_valid & bus.if_ready;

  assign entry = '{pc: pc_q, inst: bus.instruction};

  always_comb begin
    pc_d  = pc_q;
    mis_d = 1'b0;
    if (redirect_en) begin
      pc_d  = {redirect_pc[31:2], 2'b00};
      mis_d = |redirect_pc[1:0];
    end else if (capture) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (rst) begin
        pc_q  <= RESET_PC;
        mis_q <= 1'b0;
      end else begin
        pc_q  <= pc_d;
        mis_q <= mis_d;
      end
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .en_i    (clk_en),
    .push_i  (capture),
    .pop_i   (pop),
    .flush_i (redirect_en),
    .din_i   (entry),
    .dout_o  (head),
    .count_o (count)
  );

  assign bus.if_inst     = head.inst;
  assign bus.if_pc       = head.pc;
  assign fetch_misaligned = mis_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a combinational
// memory whose word at byte address A is A ^ 32'hDEADBEEF.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic     clk;
  logic     rst;
  logic     clk_en;
  logic     redirect_en;
  dataBus_t redirect_pc;
  logic     fetch_misaligned;

  int checks = 0;
  int errors = 0;

  inst_fetch_if bus ();

  inst_fetch u_dut (
    .clk              (clk),
    .rst              (rst),
    .clk_en           (clk_en),
    .bus              (bus),
    .redirect_en      (redirect_en),
    .redirect_pc      (redirect_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  assign bus.instruction = {bus.addr[29:0], 2'b00} ^ 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clk_en = 1'b1;
    redirect_en = 1'b0;
    redirect_pc = '0;
    bus.inst_ready = 1'b1;
    bus.if_ready = 1'b1;

    // reset state
    step();
    #1;
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_valid", bus.if_valid, 0);
    chk("rst_inst", bus.if_inst, 0);
    chk("rst_pc", bus.if_pc, 0);
    chk("rst_mis", fetch_misaligned, 0);
    chk("rst_addr", bus.addr, 0);

    rst = 1'b0;
    #1;
    chk("first_rd_en", bus.rd_en, 1);
    chk("first_addr", bus.addr, 0);
    chk("first_valid", bus.if_valid, 0);

    // streaming, one per cycle
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stream_addr", bus.addr, i + 1);
      chk("stream_valid", bus.if_valid, 1);
      chk("stream_pc", bus.if_pc, 4 * i);
      chk("stream_inst", bus.if_inst, mem(4 * i));
    end

    // backpressure: head 12, fill with 16, then stall
    bus.if_ready = 1'b0;
    step();
    chk("bp_rd_en", bus.rd_en, 0);
    chk("bp_addr", bus.addr, 5);
    chk("bp_pc", bus.if_pc, 12);
    repeat (3) step();
    chk("bp_hold_rd", bus.rd_en, 0);
    chk("bp_hold_addr", bus.addr, 5);
    chk("bp_hold_pc", bus.if_pc, 12);
    chk("bp_hold_valid", bus.if_valid, 1);
    bus.if_ready = 1'b1;
    step();
    chk("bp_rel_rd", bus.rd_en, 1);
    chk("bp_rel_pc", bus.if_pc, 16);
    chk("bp_rel_addr", bus.addr, 5);
    step();
    chk("bp_next_pc", bus.if_pc, 20);
    chk("bp_next_addr", bus.addr, 6);

    // memory wait at addr 6
    bus.inst_ready = 1'b0;
    repeat (3) begin
      step();
      chk("wait_rd_en", bus.rd_en, 1);
      chk("wait_addr", bus.addr, 6);
      chk("wait_valid", bus.if_valid, 0);
    end
    bus.inst_ready = 1'b1;
    step();
    chk("wait_cap_valid", bus.if_valid, 1);
    chk("wait_cap_pc", bus.if_pc, 24);
    chk("wait_cap_inst", bus.if_inst, mem(24));
    chk("wait_cap_addr", bus.addr, 7);
    step();
    chk("wait_once_pc", bus.if_pc, 28);

    // full buffer then redirect to 0x100
    bus.if_ready = 1'b0;
    step();
    chk("full_rd_en", bus.rd_en, 0);
    redirect_en = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("redir_valid", bus.if_valid, 0);
    step();
    redirect_en = 1'b0;
    bus.if_ready = 1'b1;
    #1;
    chk("redir_addr", bus.addr, 32'h40);
    chk("redir_rd_en", bus.rd_en, 1);
    chk("redir_empty", bus.if_valid, 0);
    chk("redir_mis", fetch_misaligned, 0);
    step();
    chk("redir_tgt_valid", bus.if_valid, 1);
    chk("redir_tgt_pc", bus.if_pc, 32'h100);

    // misaligned redirect
    redirect_en = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect_en = 1'b0;
    #1;
    chk("mis_pulse", fetch_misaligned, 1);
    chk("mis_addr", bus.addr, 32'h40);
    chk("mis_valid", bus.if_valid, 0);
    step();
    chk("mis_clear", fetch_misaligned, 0);
    chk("mis_tgt_pc", bus.if_pc, 32'h100);

    // PC wrap at top of address space
    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_en = 1'b0;
    #1;
    chk("wrap_addr_hi", bus.addr, 32'h3FFF_FFFF);
    step();
    chk("wrap_addr0", bus.addr, 0);
    chk("wrap_pc_hi", bus.if_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc0", bus.if_pc, 0);

    // reset mid-stream with two entries buffered
    bus.if_ready = 1'b0;
    step();
    chk("mid_full_valid", bus.if_valid, 1);
    chk("mid_full_rd", bus.rd_en, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd", bus.rd_en, 0);
    step();
    chk("mid_valid", bus.if_valid, 0);
    chk("mid_inst", bus.if_inst, 0);
    chk("mid_pc", bus.if_pc, 0);
    chk("mid_addr", bus.addr, 0);
    chk("mid_mis", fetch_misaligned, 0);
    chk("mid_rd", bus.rd_en, 0);
    rst = 1'b0;
    bus.if_ready = 1'b1;
    step();
    chk("ce_pre_pc", bus.if_pc, 0);

    // clock enable low freezes everything
    clk_en = 1'b0;
    #1;
    chk("ce_rd_en", bus.rd_en, 0);
    repeat (3) begin
      step();
      chk("ce_hold_addr", bus.addr, 1);
      chk("ce_hold_valid", bus.if_valid, 1);
      chk("ce_hold_pc", bus.if_pc, 0);
      chk("ce_hold_rd", bus.rd_en, 0);
    end
    clk_en = 1'b1;
    #1;
    chk("ce_rd_back", bus.rd_en, 1);
    step();
    chk("ce_resume_pc", bus.if_pc, 4);
    chk("ce_resume_addr", bus.addr, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
